// File: rtl/reg_file_pkg.sv
// Shared definitions for the multi-port register file.
//   DEF_DATA_W : default register width in bits
//   DEF_DEPTH  : default number of registers
//   ZERO_IDX   : index of the register hardwired to zero when ZERO_REG=1
package reg_file_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 32;
  localparam int ZERO_IDX   = 0;

endpackage

// File: rtl/reg_file_mp_if.sv
// Bus between the core (decode + writeback) and the multi-port register file.
//   WRITE1_EN/IN1ADDRESS/DATA1_IN : write port 1 (ALU / memory result)
//   WRITE2_EN/IN2ADDRESS/DATA2_IN : write port 2 (late load / MUL result)
//   OUTADDRESS / DATA_OUT         : packed read ports, port i at slice i
//   RESERVE_EN / RESERVE_ADDRESS  : decode marks a register as awaiting a write
//   BUSY_OUT / BUSY_COUNT         : pending-write status per read port / total
// Handshake: every *_EN is a single-cycle strobe sampled at the rising clock
// edge; there is no ready/backpressure, the register file accepts every strobe.
// Reads are combinational from OUTADDRESS to DATA_OUT and BUSY_OUT.
interface reg_file_mp_if #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_READ = 2
);

  logic                         WRITE1_EN;
  logic [ADDR_W-1:0]            IN1ADDRESS;
  logic [DATA_W-1:0]            DATA1_IN;
  logic                         WRITE2_EN;
  logic [ADDR_W-1:0]            IN2ADDRESS;
  logic [DATA_W-1:0]            DATA2_IN;
  logic [NUM_READ*ADDR_W-1:0]   OUTADDRESS;
  logic [NUM_READ*DATA_W-1:0]   DATA_OUT;
  logic                         RESERVE_EN;
  logic [ADDR_W-1:0]            RESERVE_ADDRESS;
  logic [NUM_READ-1:0]          BUSY_OUT;
  logic [ADDR_W:0]              BUSY_COUNT;

  modport master (
    output WRITE1_EN, IN1ADDRESS, DATA1_IN,
    output WRITE2_EN, IN2ADDRESS, DATA2_IN,
    output OUTADDRESS, RESERVE_EN, RESERVE_ADDRESS,
    input  DATA_OUT, BUSY_OUT, BUSY_COUNT
  );

  modport slave (
    input  WRITE1_EN, IN1ADDRESS, DATA1_IN,
    input  WRITE2_EN, IN2ADDRESS, DATA2_IN,
    input  OUTADDRESS, RESERVE_EN, RESERVE_ADDRESS,
    output DATA_OUT, BUSY_OUT, BUSY_COUNT
  );

endinterface

// File: rtl/reg_file_scoreboard.sv
// Pending-write scoreboard: one busy bit per register plus a registered
// population count of the busy bits.
//   clk, rst           : clock, asynchronous active-high reset
//   set_en, set_addr   : reserve (already filtered for range / zero register)
//   clr1_en, clr1_addr : committed write on port 1 (filtered)
//   clr2_en, clr2_addr : committed write on port 2 (filtered)
//   busy               : busy bit vector
//   busy_count         : number of busy bits
module reg_file_scoreboard #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr1_en,
  input  logic [ADDR_W-1:0] clr1_addr,
  input  logic              clr2_en,
  input  logic [ADDR_W-1:0] clr2_addr,
  output logic [DEPTH-1:0]  busy,
  output logic [ADDR_W:0]   busy_count
);

  localparam int CNT_W = ADDR_W + 1;

  logic [DEPTH-1:0] set_vec;
  logic [DEPTH-1:0] clr_vec;
  logic [DEPTH-1:0] busy_next;
  logic             inc;
  logic             clr1_hit;
  logic             clr2_hit;
  logic [1:0]       dec;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (set_en)  set_vec[set_addr]  = 1'b1;
    if (clr1_en) clr_vec[clr1_addr] = 1'b1;
    if (clr2_en) clr_vec[clr2_addr] = 1'b1;
    // Set after clear: a reserve in the same cycle as a write means a newer
    // producer is now pending, so the bit must stay busy.
    busy_next = (busy & ~clr_vec) | set_vec;

    inc      = set_en && !busy[set_addr];
    clr1_hit = clr1_en && busy[clr1_addr] &&
               !(set_en && (set_addr == clr1_addr));
    // Both ports hitting the same register clear one bit, counted once.
    clr2_hit = clr2_en && busy[clr2_addr] &&
               !(set_en && (set_addr == clr2_addr)) &&
               !(clr1_en && (clr1_addr == clr2_addr));
    dec      = {1'b0, clr1_hit} + {1'b0, clr2_hit};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy       <= '0;
      busy_count <= '0;
    end else begin
      busy       <= busy_next;
      busy_count <= busy_count + CNT_W'(inc) - CNT_W'(dec);
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with two write ports, NUM_READ combinational read
// ports, optional write-to-read bypass and a pending-write scoreboard.
//   CLK   : clock, all state updates on its rising edge
//   RESET : asynchronous active-high reset, clears registers and scoreboard
//   bus   : reg_file_mp_if slave (write ports, read ports, reserve, busy)
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int NUM_READ = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input logic          CLK,
  input logic          RESET,
  reg_file_mp_if.slave bus
);

  logic [DATA_W-1:0]          regs [DEPTH];
  logic [DEPTH-1:0]           busy_vec;
  logic [ADDR_W:0]            busy_count;
  logic                       we1;
  logic                       we2;
  logic                       res_ok;
  logic [NUM_READ*DATA_W-1:0] data_out;
  logic [NUM_READ-1:0]        busy_out;
  logic [ADDR_W-1:0]          ra;
  logic [DATA_W-1:0]          rd;
  logic                       rb;
  logic                       hit1;
  logic                       hit2;

  // A "live" address is in range and not the hardwired zero register; only
  // live addresses can be written, reserved, read or reported busy.
  function automatic logic live(input logic [ADDR_W-1:0] a);
    live = (int'(a) < DEPTH) &&
           !((ZERO_REG != 0) && (a == ADDR_W'(ZERO_IDX)));
  endfunction

  assign we1    = bus.WRITE1_EN  && live(bus.IN1ADDRESS);
  assign we2    = bus.WRITE2_EN  && live(bus.IN2ADDRESS);
  assign res_ok = bus.RESERVE_EN && live(bus.RESERVE_ADDRESS);

  // Port 2 is written last so it wins a same-address collision.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int r = 0; r < DEPTH; r++) regs[r] <= '0;
    end else begin
      if (we1) regs[bus.IN1ADDRESS] <= bus.DATA1_IN;
      if (we2) regs[bus.IN2ADDRESS] <= bus.DATA2_IN;
    end
  end

  reg_file_scoreboard #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk        (CLK),
    .rst        (RESET),
    .set_en     (res_ok),
    .set_addr   (bus.RESERVE_ADDRESS),
    .clr1_en    (we1),
    .clr1_addr  (bus.IN1ADDRESS),
    .clr2_en    (we2),
    .clr2_addr  (bus.IN2ADDRESS),
    .busy       (busy_vec),
    .busy_count (busy_count)
  );

  always_comb begin
    data_out = '0;
    busy_out = '0;
    ra       = '0;
    rd       = '0;
    rb       = 1'b0;
    hit1     = 1'b0;
    hit2     = 1'b0;
    for (int i = 0; i < NUM_READ; i++) begin
      ra   = bus.OUTADDRESS[i*ADDR_W +: ADDR_W];
      rd   = '0;
      rb   = 1'b0;
      hit1 = (BYPASS != 0) && we1 && (bus.IN1ADDRESS == ra);
      hit2 = (BYPASS != 0) && we2 && (bus.IN2ADDRESS == ra);
      if (live(ra)) begin
        rd = regs[ra];
        rb = busy_vec[ra];
        if (hit1) rd = bus.DATA1_IN;
        if (hit2) rd = bus.DATA2_IN;
        // The write landing this cycle resolves the pending producer.
        if (hit1 || hit2) rb = 1'b0;
      end
      // Outputs are held at zero while reset is asserted, bypass included.
      if (RESET) begin
        rd = '0;
        rb = 1'b0;
      end
      data_out[i*DATA_W +: DATA_W] = rd;
      busy_out[i]                  = rb;
    end
  end

  assign bus.DATA_OUT   = data_out;
  assign bus.BUSY_OUT   = busy_out;
  assign bus.BUSY_COUNT = busy_count;

endmodule
